// File: rtl/sweep_peak_tracker.sv
// rtl/sweep_peak_tracker.sv - sweep-and-hold peak finder with per-position averaging
// Steps through NUM_POS positions via req/ack, averages samples, publishes the best average.
module sweep_peak_tracker #(
    parameter int DATA_W   = 12,
    parameter int POS_W    = 9,
    parameter int NUM_POS  = 360,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              step_ack,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              step_req,
    output logic [POS_W-1:0]  step_pos,
    output logic              busy,
    output logic              done,
    output logic              peak_valid,
    output logic [DATA_W-1:0] peak_value,
    output logic [POS_W-1:0]  peak_pos
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_POS - 1);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_ACQ, S_CMP, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_work_peak;
    logic [POS_W-1:0]   r_work_pos;
    logic               r_first;
    logic               r_step_req;
    logic [POS_W-1:0]   r_step_pos;
    logic               r_busy;
    logic               r_done;
    logic               r_peak_valid;
    logic [DATA_W-1:0]  r_peak_value;
    logic [POS_W-1:0]   r_peak_pos;

    logic [DATA_W-1:0]  w_avg;
    logic               w_take;
    logic [DATA_W-1:0]  w_best_val;
    logic [POS_W-1:0]   w_best_pos;
    logic               w_last_sample;

    assign w_avg         = DATA_W'(r_acc >> AVG_LOG2);
    assign w_take        = r_first || (w_avg > r_work_peak);
    assign w_best_val    = w_take ? w_avg : r_work_peak;
    assign w_best_pos    = w_take ? r_step_pos : r_work_pos;
    assign w_last_sample = sample_valid && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over every transition out of a non-idle state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && !abort) w_next = S_MOVE;
            S_MOVE: begin
                if (abort)         w_next = S_IDLE;
                else if (step_ack) w_next = S_ACQ;
            end
            S_ACQ: begin
                if (abort)              w_next = S_IDLE;
                else if (w_last_sample) w_next = S_CMP;
            end
            S_CMP: begin
                if (abort)                        w_next = S_IDLE;
                else if (r_step_pos == POS_LAST)  w_next = S_DONE;
                else                              w_next = S_MOVE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_work_peak  <= '0;
            r_work_pos   <= '0;
            r_first      <= 1'b0;
            r_step_req   <= 1'b0;
            r_step_pos   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak_value <= '0;
            r_peak_pos   <= '0;
        end else begin
            r_step_req <= (w_next == S_MOVE);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_MOVE) begin
                        r_step_pos  <= '0;
                        r_work_peak <= '0;
                        r_work_pos  <= '0;
                        r_first     <= 1'b1;
                    end
                end
                S_MOVE: begin
                    if (w_next == S_ACQ) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_ACQ: begin
                    if (!abort && sample_valid) begin
                        r_acc <= r_acc + ACC_W'(sample);
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CMP: begin
                    if (!abort) begin
                        r_work_peak <= w_best_val;
                        r_work_pos  <= w_best_pos;
                        r_first     <= 1'b0;
                        if (w_next == S_MOVE) r_step_pos <= r_step_pos + POS_W'(1);
                        // Publish the result including the last position's comparison.
                        if (w_next == S_DONE) begin
                            r_peak_value <= w_best_val;
                            r_peak_pos   <= w_best_pos;
                            r_peak_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign step_req   = r_step_req;
    assign step_pos   = r_step_pos;
    assign busy       = r_busy;
    assign done       = r_done;
    assign peak_valid = r_peak_valid;
    assign peak_value = r_peak_value;
    assign peak_pos   = r_peak_pos;

endmodule

// File: tb/tb_sweep_peak_tracker.sv
// tb/tb_sweep_peak_tracker.sv - self-checking bench for sweep_peak_tracker
module tb_sweep_peak_tracker;
    localparam int DATA_W   = 12;
    localparam int POS_W    = 9;
    localparam int NUM_POS  = 4;
    localparam int AVG_LOG2 = 2;
    localparam int NS       = 1 << AVG_LOG2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              step_ack = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              step_req;
    logic [POS_W-1:0]  step_pos;
    logic              busy;
    logic              done;
    logic              peak_valid;
    logic [DATA_W-1:0] peak_value;
    logic [POS_W-1:0]  peak_pos;

    sweep_peak_tracker #(
        .DATA_W(DATA_W), .POS_W(POS_W), .NUM_POS(NUM_POS), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .step_ack(step_ack), .sample_valid(sample_valid), .sample(sample),
        .step_req(step_req), .step_pos(step_pos), .busy(busy), .done(done),
        .peak_valid(peak_valid), .peak_value(peak_value), .peak_pos(peak_pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int smp [NUM_POS][NS];
    int exp_val   = 0;
    int exp_pos   = 0;
    int exp_valid = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: plain average per position, earliest strict maximum wins.
    function automatic void model(output int v, output int p);
        int best;
        best = -1;
        p = 0;
        for (int i = 0; i < NUM_POS; i++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < NS; k++) sum += smp[i][k];
            if (sum / NS > best) begin
                best = sum / NS;
                p = i;
            end
        end
        v = best;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_outs"},
                 32'({step_req, step_pos, busy, done, peak_valid, peak_value, peak_pos}), 32'd0);
    endtask

    task automatic check_published(input string tag);
        check_eq({tag, "_val"}, 32'(peak_value), 32'(exp_val));
        check_eq({tag, "_pos"}, 32'(peak_pos), 32'(exp_pos));
        check_eq({tag, "_vld"}, 32'(peak_valid), 32'(exp_valid));
    endtask

    task automatic run_sweep(input int ack_dly, input int gap, input bit noise,
                             input bit timing, input int abort_pos, input bit rst_at_end);
        int p0, n, mv, mp;
        bit seen_done;
        model(mv, mp);
        @(negedge clk);
        start = 1'b1;
        p0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < NUM_POS; p++) begin
            n = 0;
            while (!step_req && n < 40) begin
                if (noise) begin
                    sample_valid = 1'($urandom);
                    sample = DATA_W'($urandom);
                end
                @(negedge clk);
                n++;
            end
            sample_valid = 1'b0;
            check_eq("req_up", 32'(step_req), 32'd1);
            check_eq("step_pos", 32'(step_pos), 32'(p));
            if (timing) check_eq("move_cycle", cyc - p0, 1 + p * (NS + 2));
            for (int d = 0; d < ack_dly; d++) begin
                if (noise) begin
                    sample_valid = 1'($urandom);
                    sample = DATA_W'($urandom);
                    start = 1'($urandom);
                end
                @(negedge clk);
                check_eq("req_hold", 32'(step_req), 32'd1);
            end
            step_ack = 1'b1;
            sample_valid = noise;
            sample = DATA_W'($urandom);
            @(negedge clk);
            step_ack = 1'b0;
            start = 1'b0;
            check_eq("req_drop", 32'(step_req), 32'd0);
            for (int k = 0; k < NS; k++) begin
                for (int g = 0; g < gap; g++) begin
                    sample_valid = 1'b0;
                    step_ack = noise ? 1'($urandom) : 1'b0;
                    @(negedge clk);
                end
                step_ack = 1'b0;
                sample_valid = 1'b1;
                sample = DATA_W'(smp[p][k]);
                if (p == abort_pos && k == NS / 2) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    sample_valid = 1'b0;
                    check_eq("abort_busy", 32'(busy), 32'd0);
                    check_eq("abort_req", 32'(step_req), 32'd0);
                    check_published("abort_hold");
                    seen_done = done;
                    repeat (8) begin
                        @(negedge clk);
                        seen_done |= done;
                    end
                    check_eq("abort_no_done", 32'(seen_done), 32'd0);
                    return;
                end
                @(negedge clk);
            end
            sample_valid = 1'b0;
        end
        if (rst_at_end) begin
            reset_n = 1'b0;
            #1;
            check_zero("rst_mid");
            exp_val = 0;
            exp_pos = 0;
            exp_valid = 0;
            seen_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen_done |= done;
            end
            check_eq("rst_no_done", 32'(seen_done), 32'd0);
            reset_n = 1'b1;
            return;
        end
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        if (timing) check_eq("done_cycle", cyc - p0, NUM_POS * (NS + 2) + 1);
        exp_val = mv;
        exp_pos = mp;
        exp_valid = 1;
        check_published("result");
        @(negedge clk);
        check_eq("done_clear", 32'(done), 32'd0);
        check_eq("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic load_basic();
        for (int k = 0; k < NS; k++) begin
            smp[0][k] = 100;
            smp[1][k] = (k == NS - 1) ? 203 : 200;
            smp[2][k] = 4095;
            smp[3][k] = 10;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            start = 1'($urandom);
            abort = 1'($urandom);
            step_ack = 1'($urandom);
            sample_valid = 1'($urandom);
            sample = DATA_W'($urandom);
            #1;
            check_zero("reset_hold");
        end
        @(negedge clk);
        {start, abort, step_ack, sample_valid} = 4'b0;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_idle");
        end

        load_basic();
        run_sweep(0, 0, 1'b0, 1'b1, -1, 1'b0);
        check_eq("basic_val", 32'(peak_value), 32'd4095);
        check_eq("basic_pos", 32'(peak_pos), 32'd2);

        for (int i = 0; i < NUM_POS; i++)
            for (int k = 0; k < NS; k++) smp[i][k] = (i == 3) ? 500 : 0;
        smp[1][0] = 500; smp[1][1] = 500; smp[1][2] = 500; smp[1][3] = 503;
        run_sweep(0, 0, 1'b0, 1'b1, -1, 1'b0);
        check_eq("tie_val", 32'(peak_value), 32'd500);
        check_eq("tie_pos", 32'(peak_pos), 32'd1);

        load_basic();
        run_sweep(5, 1, 1'b1, 1'b0, -1, 1'b0);
        check_eq("stall_val", 32'(peak_value), 32'd4095);
        check_eq("stall_pos", 32'(peak_pos), 32'd2);

        run_sweep(0, 0, 1'b0, 1'b0, -1, 1'b0);
        run_sweep(0, 0, 1'b0, 1'b0, 2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("idle_abort_busy", 32'(busy), 32'd0);
        check_eq("idle_abort_req", 32'(step_req), 32'd0);
        @(negedge clk);
        check_eq("idle_abort_busy2", 32'(busy), 32'd0);

        run_sweep(0, 0, 1'b0, 1'b0, -1, 1'b1);
        check_zero("post_rst");
        run_sweep(0, 0, 1'b0, 1'b1, -1, 1'b0);

        repeat (8) begin
            int range_sel;
            range_sel = $urandom_range(0, 1);
            for (int i = 0; i < NUM_POS; i++)
                for (int k = 0; k < NS; k++)
                    smp[i][k] = range_sel ? $urandom_range(0, 4095) : $urandom_range(0, 3) * 1000;
            run_sweep($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 1'b0, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sweep_peak_tracker.md
# sweep_peak_tracker

Parametrised sweep-and-hold peak finder for the sunflower tracker. It steps a position index through `NUM_POS` positions and requests each move from the motor/servo side with a req/ack handshake. At each position it averages `2^AVG_LOG2` ADC samples, keeps the highest average and the position where it occurred, and publishes that result with a done pulse. It replaces the single max register and comparator pair, adding averaging, position capture, sweep sequencing and abort.

## Interface
Parameters:
- `DATA_W`, 12, ADC sample width
- `POS_W`, 9, position index width
- `NUM_POS`, 360, positions per sweep; range 2..2^POS_W
- `AVG_LOG2`, 2, log2 of samples averaged per position; range 0..4

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; honoured only in IDLE
- `abort`  in  1  cancel the sweep; return to IDLE
- `step_ack`  in  1  motor side reports it has settled at `step_pos`
- `sample_valid`  in  1  `sample` is valid this cycle
- `sample`  in  DATA_W  raw ADC code
- `step_req`  out  1  move request for `step_pos`
- `step_pos`  out  POS_W  current position index
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a result is published
- `peak_valid`  out  1  a result has been published since reset
- `peak_value`  out  DATA_W  published best average
- `peak_pos`  out  POS_W  position of `peak_value`

## Operation
- States: IDLE, MOVE, ACQ, CMP, DONE.
- IDLE:
  - `start`=1 and `abort`=0 → MOVE.
  - Entering MOVE: `step_pos`←0, working peak ← 0, working position ← 0, first flag set.
- MOVE: `step_req`=1 (Moore output). When `step_ack`=1 is sampled → ACQ; accumulator and sample count cleared.
- ACQ:
  - Each cycle with `sample_valid`=1 adds `sample` into an accumulator `DATA_W+AVG_LOG2` bits wide; no overflow is possible.
  - When the `2^AVG_LOG2`-th sample is accepted → CMP.
- CMP:
  - avg = acc >> AVG_LOG2 (truncating).
  - If first flag is set, or avg > working peak (strict), load working peak←avg and working position←`step_pos`; clear first flag.
  - If `step_pos`==NUM_POS-1 → DONE; otherwise `step_pos`+1 and → MOVE.
- Tie-break: strict compare, so the earliest position wins.
- DONE: `done`=1; → IDLE next cycle.
- Published outputs:
  - `peak_value`, `peak_pos` and `peak_valid`←1 are loaded on the edge entering DONE.
  - They hold their previous values for the whole sweep, so they remain visible during a new sweep.
- Ignored inputs:
  - `step_ack` outside MOVE.
  - `sample_valid` outside ACQ.
  - `start` outside IDLE.
- abort:
  - In any non-IDLE state → IDLE on the next edge.
  - `step_req` drops, no `done` is issued, published outputs are unchanged.
  - Abort has priority over every other transition, including CMP on the last position and `start`.
- Async reset (`reset_n` low): state IDLE; every output 0 immediately (`step_pos`, `peak_value`, `peak_pos`, `peak_valid`, `done`, `busy`, `step_req`); accumulator, count and working registers cleared.

## Timing
- `start` is sampled at edge 0. Cycle 1 is MOVE with `step_req`=1, `step_pos`=0, `busy`=1.
- `step_req` stays high until `step_ack` is sampled, then drops the next cycle.
- Per-position minimum, with `step_ack` immediate and `sample_valid` continuous: 1 (MOVE) + 2^AVG_LOG2 (ACQ) + 1 (CMP) cycles.
- Minimum sweep: MOVE of position k at cycle 1+k·(2^AVG_LOG2+2). DONE at cycle NUM_POS·(2^AVG_LOG2+2)+1, with new outputs and `done` visible in that cycle.
- `busy` falls the cycle after DONE. `start` is accepted again from that IDLE cycle.
- All outputs are registered. `step_pos` changes only on entry to MOVE.

## Test plan
1. Reset: hold `reset_n`=0 with random inputs. All outputs must read 0. Release with no `start`: outputs stay 0 and `busy`=0.
2. Basic sweep (NUM_POS=4, AVG_LOG2=2, immediate ack, continuous valid):
   - Stimulus per position: pos0 all 100; pos1 {200,200,200,203}; pos2 all 4095; pos3 all 10.
   - Required: `done` at cycle 25; `peak_value`=4095, `peak_pos`=2, `peak_valid`=1.
3. Truncation and tie:
   - Stimulus: pos1 {500,500,500,503} (avg 500); pos3 all 500; others 0.
   - Required: `peak_value`=500, `peak_pos`=1.
4. Stalls:
   - Stimulus: `step_ack` delayed 5 cycles per position; `sample_valid` on alternate cycles; extra `sample_valid` pulses during MOVE; `start` pulsed mid-sweep.
   - Required: same result as scenario 2; `step_req` held through each stall; ignored inputs have no effect.
5. Abort:
   - Stimulus: complete scenario 2, then start a new sweep and assert `abort` during ACQ at pos2.
   - Required: `busy`=0 and `step_req`=0 the next cycle; no `done`; outputs still 4095/2.
   - Stimulus: assert `abort` and `start` together in IDLE. Required: stays IDLE.
6. Async reset mid-sweep:
   - Stimulus: drop `reset_n` in CMP of pos3.
   - Required: all outputs 0 immediately, including `peak_valid`; no `done`. A fresh sweep then completes normally.
